// File: rtl/video_pkg.sv
// Shared state encoding, default frame geometry and width helper for the
// video double-buffer controller.
package video_pkg;

    localparam int DEF_X_WIDTH  = 8;
    localparam int DEF_Y_HEIGHT = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } vbc_state_e;

    // Address width that stays at least one bit for degenerate sizes.
    function automatic int pos_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_buffer_ctrl_if.sv
// Loader pixel handshake plus the back-bank write port of the controller.
interface video_buffer_ctrl_if
    import video_pkg::*;
#(
    parameter int X_WIDTH  = DEF_X_WIDTH,
    parameter int Y_HEIGHT = DEF_Y_HEIGHT
) ();

    localparam int XW = pos_w(X_WIDTH);
    localparam int YW = pos_w(Y_HEIGHT);

    logic          pix_valid;
    logic          pix_data;
    logic          pix_ready;
    logic          bank1_we;
    logic          bank2_we;
    logic          wr_data;
    logic [XW-1:0] mem_x_pos;
    logic [YW-1:0] mem_y_pos;

    modport master (
        input  pix_valid, pix_data,
        output pix_ready, bank1_we, bank2_we, wr_data, mem_x_pos, mem_y_pos
    );

    modport slave (
        output pix_valid, pix_data,
        input  pix_ready, bank1_we, bank2_we, wr_data, mem_x_pos, mem_y_pos
    );

endinterface

// File: rtl/frame_pos_counter.sv
// Raster write-position counter: x runs fastest, wraps into y, and the whole
// position wraps to (0,0) after the last pixel of the frame.
module frame_pos_counter
    import video_pkg::*;
#(
    parameter int  X_WIDTH  = DEF_X_WIDTH,
    parameter int  Y_HEIGHT = DEF_Y_HEIGHT,
    localparam int XW       = pos_w(X_WIDTH),
    localparam int YW       = pos_w(Y_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(X_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_end;

    assign x_end = (x_q == X_LAST);
    assign last  = x_end && (y_q == Y_LAST);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_end) begin
                x_d = '0;
                y_d = last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/video_buffer_ctrl.sv
// Double-buffer controller: fills the hidden bank from the loader and swaps
// banks on a VGA frame boundary once a complete frame has been written.
module video_buffer_ctrl
    import video_pkg::*;
#(
    parameter int X_WIDTH  = DEF_X_WIDTH,
    parameter int Y_HEIGHT = DEF_Y_HEIGHT,
    parameter int CNT_W    = 8
) (
    input  logic                CLK_40,
    input  logic                reset_n,
    input  logic                en,
    input  logic                vga_frame_end,
    video_buffer_ctrl_if.master bus,
    output logic                rd_bank_sel,
    output logic                swap_pulse,
    output logic [CNT_W-1:0]    repeat_cnt,
    output logic [1:0]          state
);

    localparam int XW = pos_w(X_WIDTH);
    localparam int YW = pos_w(Y_HEIGHT);

    // Assertion is immediate; release takes effect one edge after deassertion.
    logic rst_sync_q;
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    vbc_state_e    state_q, state_d;
    logic          rd_bank_sel_q, swap_pulse_q, swap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          bank1_we_q, bank2_we_q, wr_data_q;
    logic [XW-1:0] x_q, pos_x;
    logic [YW-1:0] y_q, pos_y;
    logic          pos_last, clear_pos, pix_ready_w, accept;

    assign pix_ready_w = (state_q == FILL) && en;
    assign accept      = pix_ready_w && bus.pix_valid;

    frame_pos_counter #(
        .X_WIDTH  (X_WIDTH),
        .Y_HEIGHT (Y_HEIGHT)
    ) u_pos (
        .clk     (CLK_40),
        .rst_n   (rst_sync_q),
        .advance (accept),
        .clear   (clear_pos),
        .x       (pos_x),
        .y       (pos_y),
        .last    (pos_last)
    );

    always_comb begin
        state_d   = state_q;
        swap_d    = 1'b0;
        cnt_d     = cnt_q;
        clear_pos = 1'b0;
        unique case (state_q)
            IDLE: begin
                clear_pos = 1'b1;
                if (en) state_d = FILL;
            end
            FILL: begin
                if (!en) begin
                    state_d   = IDLE;
                    clear_pos = 1'b1;
                end else if (accept && pos_last) begin
                    // A frame boundary coinciding with the last pixel swaps at once.
                    if (vga_frame_end) swap_d  = 1'b1;
                    else               state_d = WAIT_SWAP;
                end else if (vga_frame_end && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_SWAP: begin
                if (!en) begin
                    state_d   = IDLE;
                    clear_pos = 1'b1;
                end else if (vga_frame_end) begin
                    swap_d  = 1'b1;
                    state_d = FILL;
                end
            end
            default: begin
                state_d   = IDLE;
                clear_pos = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_40 or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q       <= IDLE;
            rd_bank_sel_q <= 1'b0;
            swap_pulse_q  <= 1'b0;
            cnt_q         <= '0;
            bank1_we_q    <= 1'b0;
            bank2_we_q    <= 1'b0;
            wr_data_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            state_q       <= state_d;
            rd_bank_sel_q <= rd_bank_sel_q ^ swap_d;
            swap_pulse_q  <= swap_d;
            cnt_q         <= cnt_d;
            // Target the hidden bank as seen when the pixel was accepted.
            bank1_we_q    <= accept && !rd_bank_sel_q;
            bank2_we_q    <= accept &&  rd_bank_sel_q;
            if (accept) begin
                wr_data_q <= bus.pix_data;
                x_q       <= pos_x;
                y_q       <= pos_y;
            end
        end
    end

    assign bus.pix_ready = pix_ready_w;
    assign bus.bank1_we  = bank1_we_q;
    assign bus.bank2_we  = bank2_we_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.mem_x_pos = x_q;
    assign bus.mem_y_pos = y_q;
    assign rd_bank_sel   = rd_bank_sel_q;
    assign swap_pulse    = swap_pulse_q;
    assign repeat_cnt    = cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_video_buffer_ctrl.sv
// Scoreboard bench for video_buffer_ctrl: randomized pixel traffic against a
// frame-level reference model, with a negedge monitor checking every write.
module tb_video_buffer_ctrl;
    import video_pkg::*;

    localparam int XW_P = 8;
    localparam int YH_P = 6;
    localparam int CW   = 8;
    localparam int NPIX = XW_P * YH_P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic fe = 1'b0;
    logic rd_sel, swp;
    logic [CW-1:0] rep;
    logic [1:0] st;

    video_buffer_ctrl_if #(.X_WIDTH(XW_P), .Y_HEIGHT(YH_P)) bus ();

    video_buffer_ctrl #(.X_WIDTH(XW_P), .Y_HEIGHT(YH_P), .CNT_W(CW)) dut (
        .CLK_40        (clk),
        .reset_n       (rst_n),
        .en            (en),
        .vga_frame_end (fe),
        .bus           (bus),
        .rd_bank_sel   (rd_sel),
        .swap_pulse    (swp),
        .repeat_cnt    (rep),
        .state         (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b1;
        int x;
        int y;
        bit d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0, n_err = 0, cnt_b1 = 0, cnt_b2 = 0;

    // Reference model: state number, displayed bank, raster index, repeats.
    int  m_st = 0, m_k = 0, m_rep = 0;
    bit  m_rd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus.bank1_we || bus.bank2_we) begin
            if (bus.bank1_we) cnt_b1++;
            if (bus.bank2_we) cnt_b2++;
            $display("write b1=%0b b2=%0b x=%0d y=%0d d=%0b",
                     bus.bank1_we, bus.bank2_we, bus.mem_x_pos, bus.mem_y_pos, bus.wr_data);
            chk("single_we", 32'(bus.bank1_we & bus.bank2_we), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("we_bank1", 32'(bus.bank1_we), 32'(e.b1));
                chk("we_bank2", 32'(bus.bank2_we), 32'(!e.b1));
                chk("wr_x", 32'(bus.mem_x_pos), e.x);
                chk("wr_y", 32'(bus.mem_y_pos), e.y);
                chk("wr_data", 32'(bus.wr_data), 32'(e.d));
            end
        end
    end

    // One clock of stimulus; predicts the response from the frame rules.
    task automatic cycle(input bit v, input bit d, input bit f);
        bit acc, swap_n, exp_rdy;
        bus.pix_valid = v;
        bus.pix_data  = d;
        fe            = f;
        #1;
        exp_rdy = (m_st == 1) && en;
        chk("pix_ready", 32'(bus.pix_ready), 32'(exp_rdy));
        acc    = v && exp_rdy;
        swap_n = 1'b0;
        if (acc) exp_q.push_back('{b1: !m_rd, x: m_k % XW_P, y: m_k / XW_P, d: d});
        if (!en) begin
            m_st = 0;
            m_k  = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: begin
                    if (acc && m_k == NPIX - 1) begin
                        m_k = 0;
                        if (f) swap_n = 1'b1;
                        else   m_st = 2;
                    end else begin
                        if (acc) m_k++;
                        if (f && m_rep < (1 << CW) - 1) m_rep++;
                    end
                end
                default: if (f) begin
                    swap_n = 1'b1;
                    m_st   = 1;
                end
            endcase
        end
        @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        fe            = 1'b0;
        if (swap_n) m_rd = !m_rd;
        chk("state", 32'(st), m_st);
        chk("rd_bank_sel", 32'(rd_sel), 32'(m_rd));
        chk("swap_pulse", 32'(swp), 32'(swap_n));
        chk("repeat_cnt", 32'(rep), m_rep);
    endtask

    task automatic send_px(input bit gaps, input bit f);
        int g;
        g = gaps ? $urandom_range(0, 2) : 0;
        for (int i = 0; i < g; i++) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'($urandom_range(0, 1)), f);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(st), 0);
        chk({tag, "_rd_bank_sel"}, 32'(rd_sel), 0);
        chk({tag, "_swap_pulse"}, 32'(swp), 0);
        chk({tag, "_repeat_cnt"}, 32'(rep), 0);
        chk({tag, "_bank1_we"}, 32'(bus.bank1_we), 0);
        chk({tag, "_bank2_we"}, 32'(bus.bank2_we), 0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        chk({tag, "_mem_x"}, 32'(bus.mem_x_pos), 0);
        chk({tag, "_mem_y"}, 32'(bus.mem_y_pos), 0);
        chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 0);
    endtask

    initial begin
        int b1_snap, b2_snap;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");

        // Release: first edge only synchronises, second edge leaves IDLE.
        en    = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("sync_edge1_state", 32'(st), 0);
        @(posedge clk); #1;
        chk("sync_edge2_state", 32'(st), 1);
        m_st = 1;

        // Frame 1: back-to-back pixels, no frame boundary.
        for (int i = 0; i < NPIX; i++) send_px(1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("f1_bank1_count", cnt_b1, NPIX);
        chk("f1_bank2_count", cnt_b2, 0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("f1_swapped_rd", 32'(rd_sel), 1);
        cycle(1'b0, 1'b0, 1'b0);

        // Frame 2: gaps, three repeats during FILL, last pixel with boundary.
        for (int i = 0; i < NPIX - 1; i++) begin
            if (i == 10 || i == 20 || i == 30) cycle(1'b0, 1'b0, 1'b1);
            send_px(1'b1, 1'b0);
        end
        chk("f2_repeat3", 32'(rep), 3);
        chk("f2_rd_hold", 32'(rd_sel), 1);
        send_px(1'b1, 1'b1);
        chk("f2_coincident_state", 32'(st), 1);
        chk("f2_coincident_swap", 32'(swp), 1);
        chk("f2_coincident_rep", 32'(rep), 3);
        cycle(1'b0, 1'b0, 1'b0);
        chk("f2_bank2_count", cnt_b2, NPIX);
        chk("f2_bank1_count", cnt_b1, NPIX);

        // Frame 3: abort after 20 pixels, then restart from (0,0).
        for (int i = 0; i < 20; i++) send_px(1'b1, 1'b0);
        en = 1'b0;
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("abort_bank1_count", cnt_b1, NPIX + 20);
        en = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        send_px(1'b0, 1'b0);
        chk("reen_bank1_we", 32'(bus.bank1_we), 1);
        chk("reen_x", 32'(bus.mem_x_pos), 0);
        chk("reen_y", 32'(bus.mem_y_pos), 0);
        for (int i = 1; i < NPIX; i++) send_px(1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);

        // Frame 4: asynchronous reset mid-frame with a write in flight.
        for (int i = 0; i < 15; i++) send_px(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midreset");
        exp_q.delete();
        m_st = 0; m_k = 0; m_rep = 0; m_rd = 1'b0;
        b1_snap = cnt_b1;
        b2_snap = cnt_b2;
        bus.pix_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.pix_valid = 1'b0;
        chk("midreset_no_b1", cnt_b1, b1_snap);
        chk("midreset_no_b2", cnt_b2, b2_snap);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
